// File: rtl/divax_pkg.sv
// Shared constants and FSM state type for the divax signed saturating divider.
// The saturation limits match those used by multax.
package divax_pkg;

  localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_MAX = 32'h8000_0000;
  localparam int unsigned ITER    = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } divax_state_e;

endpackage

// File: rtl/divax_if.sv
// Operand and result handshake bundle for divax.
// The slave side is the divider; the master side is its operand source and result consumer.
interface divax_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [31:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x_out;
  logic [15:0] r_out;
  logic        sat;
  logic        div_zero;

  modport slave (
    input  in_valid, a, x_in, out_ready,
    output in_ready, out_valid, x_out, r_out, sat, div_zero
  );

  modport master (
    output in_valid, a, x_in, out_ready,
    input  in_ready, out_valid, x_out, r_out, sat, div_zero
  );

endinterface

// File: rtl/divax_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module divax_step (
  input  logic [16:0] rem,
  input  logic        dvd_bit,
  input  logic [15:0] divisor,
  output logic [16:0] rem_next,
  output logic        q_bit
);

  logic [17:0] shifted;
  logic [16:0] diff;

  always_comb begin
    shifted  = {rem, dvd_bit};
    q_bit    = (shifted >= {2'b00, divisor});
    // Only used when q_bit is set; then shifted < 2*divisor, so 17 bits hold the result.
    diff     = shifted[16:0] - {1'b0, divisor};
    rem_next = q_bit ? diff : shifted[16:0];
  end

endmodule

// File: rtl/divax.sv
// Sequential signed divider: x_in / a truncated toward zero with remainder, one quotient
// bit per cycle, saturating on divide-by-zero and on -2^31 / -1.
module divax
  import divax_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  divax_if.slave  bus
);

  divax_state_e state_q, state_d;

  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;      // dividend magnitude shifting out, quotient bits shifting in
  logic [16:0] rem_q;
  logic [15:0] div_mag_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] x_out_q;
  logic [15:0] r_out_q;
  logic        sat_q;
  logic        div_zero_q;

  logic [31:0] x_mag;
  logic [15:0] a_mag;
  logic        is_zero;
  logic        is_ovf;
  logic        special;
  logic [16:0] rem_next;
  logic        q_bit;
  logic [31:0] q_mag;

  // Unsigned magnitudes: -2^31 and -2^15 map exactly to 2^31 and 2^15.
  always_comb begin
    x_mag   = bus.x_in[31] ? (~bus.x_in + 32'd1) : bus.x_in;
    a_mag   = bus.a[15] ? (~bus.a + 16'd1) : bus.a;
    is_zero = (bus.a == 16'h0000);
    is_ovf  = (bus.x_in == NEG_MAX) && (bus.a == 16'hFFFF);
    special = is_zero || is_ovf;
    q_mag   = {dvd_q[30:0], q_bit};
  end

  divax_step u_step (
    .rem      (rem_q),
    .dvd_bit  (dvd_q[31]),
    .divisor  (div_mag_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = special ? StDone : StCalc;
      StCalc: if (cnt_q == 5'(ITER - 1)) state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      div_mag_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      x_out_q    <= '0;
      r_out_q    <= '0;
      sat_q      <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (is_zero) begin
              x_out_q    <= bus.x_in[31] ? NEG_MAX : POS_MAX;
              r_out_q    <= '0;
              sat_q      <= 1'b1;
              div_zero_q <= 1'b1;
            end else if (is_ovf) begin
              x_out_q    <= POS_MAX;
              r_out_q    <= '0;
              sat_q      <= 1'b1;
              div_zero_q <= 1'b0;
            end else begin
              cnt_q     <= '0;
              dvd_q     <= x_mag;
              rem_q     <= '0;
              div_mag_q <= a_mag;
              neg_quo_q <= bus.x_in[31] ^ bus.a[15];
              neg_rem_q <= bus.x_in[31];
            end
          end
        end
        StCalc: begin
          cnt_q <= cnt_q + 5'd1;
          dvd_q <= q_mag;
          rem_q <= rem_next;
          if (cnt_q == 5'(ITER - 1)) begin
            x_out_q    <= neg_quo_q ? (~q_mag + 32'd1) : q_mag;
            r_out_q    <= neg_rem_q ? (~rem_next[15:0] + 16'd1) : rem_next[15:0];
            sat_q      <= 1'b0;
            div_zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.x_out     = x_out_q;
  assign bus.r_out     = r_out_q;
  assign bus.sat       = sat_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_divax.sv
// Directed self-checking bench for divax: latency, sign handling, saturation, backpressure
// and asynchronous abort.
module tb_divax;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  divax_if bus ();

  divax dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a rising edge with in_ready high; returns edges from accept to out_valid.
  task automatic run_op(input logic [31:0] xv, input logic [15:0] av, output int cyc);
    bus.x_in     = xv;
    bus.a        = av;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_in     = 32'h5A5A_1234;
    bus.a        = 16'h0003;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    n_cmp++;
    if (bus.x_out !== 32'd0 || bus.r_out !== 16'd0 || bus.sat !== 1'b0 || bus.div_zero !== 1'b0)
    begin
      n_err++;
      $display("FAIL reset_out x=%h r=%h sat=%b dz=%b required all zero",
               bus.x_out, bus.r_out, bus.sat, bus.div_zero);
    end
  endtask

  task automatic test_basic();
    int cyc;
    run_op(32'd100, 16'd7, cyc);
    n_cmp++;
    if (cyc !== 32) begin
      n_err++; $display("FAIL basic_latency got %0d required 32", cyc);
    end
    n_cmp++;
    if (bus.x_out !== 32'd14 || bus.r_out !== 16'd2) begin
      n_err++; $display("FAIL basic_100_7 x=%h r=%h required 0000000e/0002", bus.x_out, bus.r_out);
    end
    n_cmp++;
    if (bus.sat !== 1'b0 || bus.div_zero !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_flags sat=%b dz=%b in_ready=%b required 0/0/0",
               bus.sat, bus.div_zero, bus.in_ready);
    end
    take_result();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_handoff out_valid=%b in_ready=%b required 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_signs();
    int cyc;
    run_op(32'hFFFF_FF9C, 16'd7, cyc);  // -100 / 7
    n_cmp++;
    if (cyc !== 32 || bus.x_out !== 32'hFFFF_FFF2 || bus.r_out !== 16'hFFFE) begin
      n_err++;
      $display("FAIL neg_dividend cyc=%0d x=%h r=%h required 32/fffffff2/fffe",
               cyc, bus.x_out, bus.r_out);
    end
    take_result();
    run_op(32'd100, 16'hFFF9, cyc);     // 100 / -7
    n_cmp++;
    if (cyc !== 32 || bus.x_out !== 32'hFFFF_FFF2 || bus.r_out !== 16'h0002) begin
      n_err++;
      $display("FAIL neg_divisor cyc=%0d x=%h r=%h required 32/fffffff2/0002",
               cyc, bus.x_out, bus.r_out);
    end
    take_result();
  endtask

  task automatic test_overflow();
    int cyc;
    run_op(32'h8000_0000, 16'hFFFF, cyc);
    n_cmp++;
    if (cyc !== 0 || bus.x_out !== 32'h7FFF_FFFF || bus.r_out !== 16'd0) begin
      n_err++;
      $display("FAIL ovf_result cyc=%0d x=%h r=%h required 0/7fffffff/0000",
               cyc, bus.x_out, bus.r_out);
    end
    n_cmp++;
    if (bus.sat !== 1'b1 || bus.div_zero !== 1'b0) begin
      n_err++; $display("FAIL ovf_flags sat=%b dz=%b required 1/0", bus.sat, bus.div_zero);
    end
    take_result();
  endtask

  task automatic test_div_zero();
    int cyc;
    run_op(32'd5, 16'd0, cyc);
    n_cmp++;
    if (cyc !== 0 || bus.x_out !== 32'h7FFF_FFFF || bus.sat !== 1'b1 || bus.div_zero !== 1'b1)
    begin
      n_err++;
      $display("FAIL dz_pos cyc=%0d x=%h sat=%b dz=%b required 0/7fffffff/1/1",
               cyc, bus.x_out, bus.sat, bus.div_zero);
    end
    take_result();
    run_op(32'hFFFF_FFFB, 16'd0, cyc);
    n_cmp++;
    if (cyc !== 0 || bus.x_out !== 32'h8000_0000 || bus.r_out !== 16'd0 ||
        bus.div_zero !== 1'b1) begin
      n_err++;
      $display("FAIL dz_neg cyc=%0d x=%h r=%h dz=%b required 0/80000000/0000/1",
               cyc, bus.x_out, bus.r_out, bus.div_zero);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    run_op(32'h8000_0000, 16'h8000, cyc);
    n_cmp++;
    if (cyc !== 32 || bus.x_out !== 32'h0001_0000 || bus.r_out !== 16'd0 || bus.sat !== 1'b0)
    begin
      n_err++;
      $display("FAIL minmin cyc=%0d x=%h r=%h sat=%b required 32/00010000/0000/0",
               cyc, bus.x_out, bus.r_out, bus.sat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.x_out !== 32'h0001_0000 ||
          bus.r_out !== 16'd0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL backpressure_hold got %0d unstable cycles required 0", bad);
    end
    take_result();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b required 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_abort_reset();
    int cyc;
    bus.x_in     = 32'd100;
    bus.a        = 16'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.x_out !== 32'd0 ||
        bus.r_out !== 16'd0 || bus.sat !== 1'b0 || bus.div_zero !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state rdy=%b vld=%b x=%h r=%h sat=%b dz=%b required 1/0/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.x_out, bus.r_out, bus.sat, bus.div_zero);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_no_output out_valid=%b required 0", bus.out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd1000, 16'd10, cyc);
    n_cmp++;
    if (cyc !== 32 || bus.x_out !== 32'd100 || bus.r_out !== 16'd0) begin
      n_err++;
      $display("FAIL after_abort cyc=%0d x=%h r=%h required 32/00000064/0000",
               cyc, bus.x_out, bus.r_out);
    end
    take_result();
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.x_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_backpressure();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
